// File: rtl/dso_dm_pkg.sv
// -----------------------------------------------------------------------------
// dso_dm_pkg
// Shared definitions for the AXI DataMover command paths of the capture
// subsystem.
//   - dm_state_e    : scheduler state encoding (IDLE / RUN / DRAIN / ERROR)
//   - CMD_*         : bit positions of the 72-bit DataMover command fields
//   - pack_s2mm_cmd : builds a 72-bit command (INCR, EOF set, DRR/DSA zero).
//                     The same layout applies to MM2S, so the function is
//                     meant to be reused there.
// -----------------------------------------------------------------------------
package dso_dm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ERROR = 2'd3
   } dm_state_e;

   localparam int unsigned CMD_W         = 72;
   localparam int unsigned CMD_RSVD_MSB  = 71;
   localparam int unsigned CMD_RSVD_LSB  = 68;
   localparam int unsigned CMD_TAG_MSB   = 67;
   localparam int unsigned CMD_TAG_LSB   = 64;
   localparam int unsigned CMD_SADDR_MSB = 63;
   localparam int unsigned CMD_SADDR_LSB = 32;
   localparam int unsigned CMD_DRR_BIT   = 31;
   localparam int unsigned CMD_EOF_BIT   = 30;
   localparam int unsigned CMD_DSA_MSB   = 29;
   localparam int unsigned CMD_DSA_LSB   = 24;
   localparam int unsigned CMD_TYPE_BIT  = 23;
   localparam int unsigned CMD_BTT_MSB   = 22;
   localparam int unsigned CMD_BTT_LSB   = 0;

   // Every chunk is a complete frame: EOF set, incrementing burst, no realign.
   function automatic logic [CMD_W-1:0] pack_s2mm_cmd(
      input logic [3:0]  tag,
      input logic [31:0] addr,
      input logic [22:0] btt
   );
      logic [CMD_W-1:0] cmd;
      cmd                              = {CMD_W{1'b0}};
      cmd[CMD_RSVD_MSB:CMD_RSVD_LSB]   = 4'h0;
      cmd[CMD_TAG_MSB:CMD_TAG_LSB]     = tag;
      cmd[CMD_SADDR_MSB:CMD_SADDR_LSB] = addr;
      cmd[CMD_DRR_BIT]                 = 1'b0;
      cmd[CMD_EOF_BIT]                 = 1'b1;
      cmd[CMD_DSA_MSB:CMD_DSA_LSB]     = 6'd0;
      cmd[CMD_TYPE_BIT]                = 1'b1;
      cmd[CMD_BTT_MSB:CMD_BTT_LSB]     = btt;
      return cmd;
   endfunction

endpackage

// File: rtl/s2mm_ring_scheduler.sv
// -----------------------------------------------------------------------------
// s2mm_ring_scheduler
// Issues one DataMover S2MM command per buffered capture chunk so that ADC data
// lands in a DDR ring of BUF_CHUNKS chunks of CHUNK_BYTES each, keeping at most
// MAX_OUTSTANDING commands in flight, and publishes ring progress for the host.
//
// Ports
//   axi_aclk           in   sole clock
//   rst                in   synchronous active-high reset
//   enable             in   run request (synchronous to axi_aclk)
//   clear_err          in   clears sticky errors; honoured in ERROR with enable=0
//   chunk_ready        in   one pulse per chunk buffered upstream
//   cmd_tdata/tvalid   out  AXIS S2MM command (72 bits)
//   cmd_tready         in   AXIS ready
//   s2mm_wr_xfer_cmplt in   one pulse per completed command
//   s2mm_err/s2mm_halt in   DataMover fault indications
//   wr_ptr             out  ring index of the next chunk to complete
//   cmplt_total        out  completed chunks since reset (wraps)
//   outstanding        out  commands accepted but not yet completed
//   overflow           out  sticky: a chunk was lost to pending saturation
//   err                out  sticky: [0] DataMover fault, [1] spurious completion
//   busy               out  scheduler not IDLE
// -----------------------------------------------------------------------------
module s2mm_ring_scheduler
   import dso_dm_pkg::*;
#(
   parameter logic [31:0] BUF_BASE        = 32'h0000_0000,
   parameter int unsigned CHUNK_BYTES     = 4096,
   parameter int unsigned BUF_CHUNKS      = 1024,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned PEND_MAX        = 15
) (
   input  logic                          axi_aclk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          clear_err,
   input  logic                          chunk_ready,
   output logic [71:0]                   cmd_tdata,
   output logic                          cmd_tvalid,
   input  logic                          cmd_tready,
   input  logic                          s2mm_wr_xfer_cmplt,
   input  logic                          s2mm_err,
   input  logic                          s2mm_halt,
   output logic [$clog2(BUF_CHUNKS)-1:0] wr_ptr,
   output logic [31:0]                   cmplt_total,
   output logic [3:0]                    outstanding,
   output logic                          overflow,
   output logic [1:0]                    err,
   output logic                          busy
);

   localparam int unsigned     PTR_W      = $clog2(BUF_CHUNKS);
   localparam int unsigned     PEND_W     = $clog2(PEND_MAX + 1);
   localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(BUF_CHUNKS - 1);
   localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1'b1);
   localparam logic [PEND_W-1:0] PEND_ZERO  = {PEND_W{1'b0}};
   localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1'b1);
   localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(PEND_MAX);
   localparam logic [3:0]        MAX_OUT_4  = 4'(MAX_OUTSTANDING);
   localparam logic [31:0]       CHUNK_32   = 32'(CHUNK_BYTES);
   localparam logic [22:0]       BTT_23     = 23'(CHUNK_BYTES);

   dm_state_e          state_r;
   dm_state_e          next_state_s;
   logic [71:0]        cmd_tdata_r;
   logic               cmd_tvalid_r;
   logic [PTR_W-1:0]   issue_idx_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [3:0]         tag_r;
   logic [PEND_W-1:0]  pending_r;
   logic [3:0]         outstanding_r;
   logic [31:0]        cmplt_total_r;
   logic               overflow_r;
   logic [1:0]         err_r;
   logic               busy_r;

   logic               dm_fault_s;
   logic               hs_s;
   logic               cmplt_s;
   logic               issue_s;
   logic               chunk_acc_s;
   logic               err_entry_s;
   logic               clear_s;
   logic               run_entry_s;
   logic [31:0]        saddr_s;

   assign dm_fault_s = s2mm_err | s2mm_halt;
   assign hs_s       = cmd_tvalid_r & cmd_tready;
   assign cmplt_s    = s2mm_wr_xfer_cmplt;
   assign saddr_s    = BUF_BASE + (32'(issue_idx_r) * CHUNK_32);

   // State register
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; a DataMover fault outranks every other transition
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (dm_fault_s) begin
               next_state_s = ST_ERROR;
            end else if (!enable) begin
               next_state_s = ST_DRAIN;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (dm_fault_s) begin
               next_state_s = ST_ERROR;
            end else if ((outstanding_r == 4'd0) && !cmd_tvalid_r) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_DRAIN;
            end
         end
         ST_ERROR: begin
            if (clear_err && !enable) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_ERROR;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Per-state control strobes; no issue on the cycle RUN is being left
   always_comb begin
      issue_s     = 1'b0;
      chunk_acc_s = 1'b0;
      err_entry_s = 1'b0;
      clear_s     = 1'b0;
      run_entry_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            run_entry_s = (next_state_s == ST_RUN);
         end
         ST_RUN: begin
            chunk_acc_s = chunk_ready;
            err_entry_s = dm_fault_s;
            issue_s     = (next_state_s == ST_RUN) && !cmd_tvalid_r &&
                          (pending_r != PEND_ZERO) && (outstanding_r < MAX_OUT_4);
         end
         ST_DRAIN: begin
            err_entry_s = dm_fault_s;
         end
         ST_ERROR: begin
            clear_s = (next_state_s == ST_IDLE);
         end
         default: begin
            issue_s = 1'b0;
         end
      endcase
   end

   // Command channel: valid drops after each handshake and on any fault
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         cmd_tvalid_r <= 1'b0;
         cmd_tdata_r  <= 72'd0;
      end else if (err_entry_s || (state_r == ST_ERROR)) begin
         cmd_tvalid_r <= 1'b0;
      end else if (issue_s) begin
         cmd_tvalid_r <= 1'b1;
         cmd_tdata_r  <= pack_s2mm_cmd(tag_r, saddr_s, BTT_23);
      end else if (hs_s) begin
         cmd_tvalid_r <= 1'b0;
      end
   end

   // Issue side: tag and ring index advance on each accepted command
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         tag_r       <= 4'd0;
         issue_idx_r <= PTR_ZERO;
      end else if (hs_s) begin
         tag_r <= tag_r + 4'd1;
         if (issue_idx_r == PTR_LAST) begin
            issue_idx_r <= PTR_ZERO;
         end else begin
            issue_idx_r <= issue_idx_r + PTR_ONE;
         end
      end
   end

   // Completion side: ring write pointer and running total
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         wr_ptr_r      <= PTR_ZERO;
         cmplt_total_r <= 32'd0;
      end else if (cmplt_s) begin
         cmplt_total_r <= cmplt_total_r + 32'd1;
         if (wr_ptr_r == PTR_LAST) begin
            wr_ptr_r <= PTR_ZERO;
         end else begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
      end
   end

   // Pending chunks; a simultaneous arrival and handshake cancel out
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         pending_r <= PEND_ZERO;
      end else if (run_entry_s || clear_s) begin
         pending_r <= PEND_ZERO;
      end else begin
         case ({chunk_acc_s, hs_s})
            2'b10: begin
               if (pending_r != PEND_LIMIT) begin
                  pending_r <= pending_r + PEND_ONE;
               end
            end
            2'b01: begin
               if (pending_r != PEND_ZERO) begin
                  pending_r <= pending_r - PEND_ONE;
               end
            end
            default: begin
               pending_r <= pending_r;
            end
         endcase
      end
   end

   // Commands in flight; a completion with nothing in flight is not counted
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         outstanding_r <= 4'd0;
      end else if (clear_s) begin
         outstanding_r <= 4'd0;
      end else begin
         case ({hs_s, cmplt_s})
            2'b10: begin
               outstanding_r <= outstanding_r + 4'd1;
            end
            2'b01: begin
               if (outstanding_r != 4'd0) begin
                  outstanding_r <= outstanding_r - 4'd1;
               end
            end
            default: begin
               outstanding_r <= outstanding_r;
            end
         endcase
      end
   end

   // Sticky status flags, cleared only by an honoured clear_err
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         overflow_r <= 1'b0;
         err_r      <= 2'b00;
      end else if (clear_s) begin
         overflow_r <= 1'b0;
         err_r      <= 2'b00;
      end else begin
         if (chunk_acc_s && !hs_s && (pending_r == PEND_LIMIT)) begin
            overflow_r <= 1'b1;
         end
         if (err_entry_s) begin
            err_r[0] <= 1'b1;
         end
         if (cmplt_s && (outstanding_r == 4'd0)) begin
            err_r[1] <= 1'b1;
         end
      end
   end

   // Busy follows the state register, registered directly from next state
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= (next_state_s != ST_IDLE);
      end
   end

   assign cmd_tdata   = cmd_tdata_r;
   assign cmd_tvalid  = cmd_tvalid_r;
   assign wr_ptr      = wr_ptr_r;
   assign cmplt_total = cmplt_total_r;
   assign outstanding = outstanding_r;
   assign overflow    = overflow_r;
   assign err         = err_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_s2mm_ring_scheduler.sv
// -----------------------------------------------------------------------------
// tb_s2mm_ring_scheduler
// Directed bench for s2mm_ring_scheduler with a count-based reference model
// (commands issued / completed as running totals, fields derived by modulo
// arithmetic) compared against the DUT on every falling edge, plus literal
// expectations at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_s2mm_ring_scheduler;

   localparam logic [31:0] P_BASE  = 32'h1000_0000;
   localparam int          P_CHUNK = 4096;
   localparam int          P_NBUF  = 4;
   localparam int          P_MAXO  = 2;
   localparam int          P_PEND  = 15;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DRN  = 2;
   localparam int M_ERR  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        clear_err = 1'b0;
   logic        chunk_ready = 1'b0;
   logic        cmd_tready = 1'b0;
   logic        s2mm_wr_xfer_cmplt = 1'b0;
   logic        s2mm_err = 1'b0;
   logic        s2mm_halt = 1'b0;
   logic [71:0] cmd_tdata;
   logic        cmd_tvalid;
   logic [1:0]  wr_ptr;
   logic [31:0] cmplt_total;
   logic [3:0]  outstanding;
   logic        overflow;
   logic [1:0]  err;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   s2mm_ring_scheduler #(
      .BUF_BASE       (P_BASE),
      .CHUNK_BYTES    (P_CHUNK),
      .BUF_CHUNKS     (P_NBUF),
      .MAX_OUTSTANDING(P_MAXO),
      .PEND_MAX       (P_PEND)
   ) dut (
      .axi_aclk          (clk),
      .rst               (rst),
      .enable            (enable),
      .clear_err         (clear_err),
      .chunk_ready       (chunk_ready),
      .cmd_tdata         (cmd_tdata),
      .cmd_tvalid        (cmd_tvalid),
      .cmd_tready        (cmd_tready),
      .s2mm_wr_xfer_cmplt(s2mm_wr_xfer_cmplt),
      .s2mm_err          (s2mm_err),
      .s2mm_halt         (s2mm_halt),
      .wr_ptr            (wr_ptr),
      .cmplt_total       (cmplt_total),
      .outstanding       (outstanding),
      .overflow          (overflow),
      .err               (err),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          m_mode    = M_IDLE;
   int          m_pending = 0;
   int          m_out     = 0;
   int          m_issued  = 0;
   logic [31:0] m_cmplt   = 32'd0;
   logic        m_valid   = 1'b0;
   logic [71:0] m_data    = 72'd0;
   logic        m_ovf     = 1'b0;
   logic [1:0]  m_err     = 2'b00;
   logic        m_busy    = 1'b0;
   logic        m_live    = 1'b0;

   function automatic logic [71:0] exp_cmd(input int n);
      logic [3:0]  tag;
      logic [31:0] addr;
      tag  = 4'(n % 16);
      addr = P_BASE + 32'((n % P_NBUF) * P_CHUNK);
      return {4'h0, tag, addr, 8'h40, 1'b1, 23'd4096};
   endfunction

   always @(posedge clk) begin : model
      int nm, np, no;
      logic hs, cp, issue, ovf_now;
      if (rst) begin
         m_mode <= M_IDLE; m_pending <= 0; m_out <= 0; m_issued <= 0;
         m_cmplt <= 32'd0; m_valid <= 1'b0; m_data <= 72'd0;
         m_ovf <= 1'b0; m_err <= 2'b00; m_busy <= 1'b0; m_live <= 1'b1;
      end else begin
         hs = m_valid && cmd_tready;
         cp = s2mm_wr_xfer_cmplt;
         nm = m_mode;
         if (m_mode == M_IDLE && enable) nm = M_RUN;
         else if ((m_mode == M_RUN || m_mode == M_DRN) && (s2mm_err || s2mm_halt)) nm = M_ERR;
         else if (m_mode == M_RUN && !enable) nm = M_DRN;
         else if (m_mode == M_DRN && m_out == 0 && !m_valid) nm = M_IDLE;
         else if (m_mode == M_ERR && clear_err && !enable) nm = M_IDLE;
         issue = (m_mode == M_RUN) && (nm == M_RUN) && !m_valid &&
                 (m_pending > 0) && (m_out < P_MAXO);
         np = m_pending + ((m_mode == M_RUN && chunk_ready) ? 1 : 0) - (hs ? 1 : 0);
         ovf_now = (np > P_PEND);
         if (np > P_PEND) np = P_PEND;
         if (np < 0) np = 0;
         if (m_mode == M_IDLE && nm == M_RUN) np = 0;
         no = m_out + (hs ? 1 : 0) - (cp ? 1 : 0);
         if (no < 0) no = 0;
         m_issued <= m_issued + (hs ? 1 : 0);
         m_cmplt  <= m_cmplt + (cp ? 32'd1 : 32'd0);
         if (m_mode == M_ERR || nm == M_ERR) m_valid <= 1'b0;
         else if (issue) begin
            m_valid <= 1'b1;
            m_data  <= exp_cmd(m_issued);
         end else if (hs) m_valid <= 1'b0;
         if (m_mode == M_ERR && nm == M_IDLE) begin
            m_pending <= 0; m_out <= 0; m_ovf <= 1'b0; m_err <= 2'b00;
         end else begin
            m_pending <= np;
            m_out     <= no;
            if (ovf_now) m_ovf <= 1'b1;
            m_err <= m_err | {(cp && m_out == 0), (nm == M_ERR && m_mode != M_ERR)};
         end
         m_mode <= nm;
         m_busy <= (nm != M_IDLE);
      end
   end

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (m_live) begin
         chk("m_tvalid", 72'(cmd_tvalid), 72'(m_valid));
         chk("m_tdata", cmd_tdata, m_data);
         chk("m_wr_ptr", 72'(wr_ptr), 72'(m_cmplt % 32'(P_NBUF)));
         chk("m_cmplt_total", 72'(cmplt_total), 72'(m_cmplt));
         chk("m_outstanding", 72'(outstanding), 72'(m_out));
         chk("m_overflow", 72'(overflow), 72'(m_ovf));
         chk("m_err", 72'(err), 72'(m_err));
         chk("m_busy", 72'(busy), 72'(m_busy));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_chunk();
      chunk_ready = 1'b1;
      tick();
      chunk_ready = 1'b0;
   endtask

   task automatic pulse_cmplt();
      s2mm_wr_xfer_cmplt = 1'b1;
      tick();
      s2mm_wr_xfer_cmplt = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (cmd_tvalid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s: cmd_tvalid never rose within 20 cycles", name);
      end
   endtask

   logic [31:0] wrap_addr [5];

   initial begin
      wrap_addr[0] = 32'h1000_0000;
      wrap_addr[1] = 32'h1000_1000;
      wrap_addr[2] = 32'h1000_2000;
      wrap_addr[3] = 32'h1000_3000;
      wrap_addr[4] = 32'h1000_0000;

      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_tvalid", 72'(cmd_tvalid), 72'd0);
      chk("rst_busy", 72'(busy), 72'd0);
      chk("rst_outstanding", 72'(outstanding), 72'd0);

      // 1. basic issue
      enable = 1'b1; cmd_tready = 1'b1;
      tick();
      pulse_chunk();
      wait_valid("t1_valid");
      chk("t1_cmd", cmd_tdata, 72'h00_1000_0000_4080_1000);
      tick(); tick();
      @(negedge clk);
      chk("t1_outstanding", 72'(outstanding), 72'd1);
      pulse_cmplt();
      @(negedge clk);
      chk("t1_wr_ptr", 72'(wr_ptr), 72'd1);
      chk("t1_cmplt_total", 72'(cmplt_total), 72'd1);

      // 2. ring wrap from a fresh reset
      rst = 1'b1; tick(); rst = 1'b0; tick();
      for (int i = 0; i < 5; i++) begin
         pulse_chunk();
         wait_valid("t2_valid");
         chk("t2_addr", 72'(cmd_tdata[63:32]), 72'(wrap_addr[i]));
         chk("t2_tag", 72'(cmd_tdata[67:64]), 72'(i));
         tick();
         pulse_cmplt();
      end
      @(negedge clk);
      chk("t2_wr_ptr", 72'(wr_ptr), 72'd1);
      chk("t2_cmplt_total", 72'(cmplt_total), 72'd5);

      // 3. backpressure and outstanding throttle
      cmd_tready = 1'b0;
      pulse_chunk(); pulse_chunk(); pulse_chunk();
      wait_valid("t3_valid");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", 72'(cmd_tvalid), 72'd1);
         chk("t3_hold_data", cmd_tdata, 72'h05_1000_1000_4080_1000);
      end
      tick();
      cmd_tready = 1'b1;
      repeat (8) tick();
      @(negedge clk);
      chk("t3_outstanding", 72'(outstanding), 72'd2);
      chk("t3_throttled", 72'(cmd_tvalid), 72'd0);
      pulse_cmplt();
      wait_valid("t3_third");
      chk("t3_third_cmd", cmd_tdata, 72'h07_1000_3000_4080_1000);
      tick();

      // 4. simultaneous handshake + completion, then pending saturation
      pulse_cmplt(); pulse_cmplt();
      pulse_chunk();
      repeat (4) tick();
      cmd_tready = 1'b0;
      pulse_chunk();
      wait_valid("t4_valid");
      tick();
      cmd_tready = 1'b1; s2mm_wr_xfer_cmplt = 1'b1;
      tick();
      cmd_tready = 1'b0; s2mm_wr_xfer_cmplt = 1'b0;
      @(negedge clk);
      chk("t4_simul_outstanding", 72'(outstanding), 72'd1);
      pulse_cmplt();
      chunk_ready = 1'b1;
      repeat (16) tick();
      chunk_ready = 1'b0;
      @(negedge clk);
      chk("t4_overflow", 72'(overflow), 72'd1);

      // 5. stop and drain
      cmd_tready = 1'b1;
      repeat (8) tick();
      @(negedge clk);
      chk("t5_outstanding", 72'(outstanding), 72'd2);
      enable = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_busy", 72'(busy), 72'd1);
         chk("t5_no_issue", 72'(cmd_tvalid), 72'd0);
      end
      tick();
      pulse_cmplt(); pulse_cmplt();
      tick(); tick();
      @(negedge clk);
      chk("t5_idle", 72'(busy), 72'd0);

      // 6. halt, clear, reset mid-run, spurious completion
      enable = 1'b1;
      tick();
      cmd_tready = 1'b0;
      pulse_chunk();
      wait_valid("t6_valid");
      tick();
      s2mm_halt = 1'b1;
      tick();
      s2mm_halt = 1'b0;
      @(negedge clk);
      chk("t6_halt_tvalid", 72'(cmd_tvalid), 72'd0);
      chk("t6_halt_err", 72'(err), 72'd1);
      enable = 1'b0; clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      @(negedge clk);
      chk("t6_clear_err", 72'(err), 72'd0);
      chk("t6_clear_busy", 72'(busy), 72'd0);
      chk("t6_clear_ovf", 72'(overflow), 72'd0);
      enable = 1'b1; cmd_tready = 1'b1;
      tick();
      pulse_chunk();
      repeat (4) tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("t6_rst_tdata", cmd_tdata, 72'd0);
      chk("t6_rst_tvalid", 72'(cmd_tvalid), 72'd0);
      chk("t6_rst_wr_ptr", 72'(wr_ptr), 72'd0);
      chk("t6_rst_total", 72'(cmplt_total), 72'd0);
      chk("t6_rst_outstanding", 72'(outstanding), 72'd0);
      chk("t6_rst_busy", 72'(busy), 72'd0);
      chk("t6_rst_err", 72'(err), 72'd0);
      rst = 1'b0;
      tick();
      pulse_cmplt();
      @(negedge clk);
      chk("t6_spurious_err", 72'(err), 72'd2);
      chk("t6_spurious_out", 72'(outstanding), 72'd0);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

endmodule
